// File: rtl/gray_port_arbiter.sv
// Round-robin arbiter for the shared gray-image read port, with locked bursts
// and a tag pipeline that steers each returning pixel back to its requester.
module gray_port_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 14,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_grant,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 gray_req,
  output logic [AW-1:0]        gray_addr,
  input  logic                 gray_ready,
  input  logic [DW-1:0]        gray_data
);

  localparam int IW  = $clog2(NREQ);
  localparam int NST = MEM_LAT + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            gray_req_q, gray_req_d;
  logic [AW-1:0]   gray_addr_q, gray_addr_d;
  logic [NST-1:0]  tag_vld_q, tag_vld_d;
  logic [IW-1:0]   tag_idx_q [NST];
  logic [IW-1:0]   tag_idx_d [NST];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic [AW-1:0]   addr_arr [NREQ];
  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic            hold_lock;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
    end
  end

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    hold_lock = (state_q == LOCKED) && req_lock[owner_q];
    if (gray_ready && reset) begin
      if (hold_lock) begin
        grant_any = req_valid[owner_q];
        grant_idx = owner_q;
      end else begin
        for (int k = NREQ; k >= 1; k--) begin
          cand = int'(ptr_q) + k;
          if (cand >= NREQ) cand = cand - NREQ;
          cand_idx = IW'(cand);
          if (req_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
          end
        end
      end
    end
  end

  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[grant_idx] = 1'b1;
  end

  // Lock FSM plus round-robin pointer and lock owner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (grant_any) begin
      ptr_d   = grant_idx;
      owner_d = grant_idx;
    end
    case (state_q)
      IDLE: begin
        if (grant_any && req_lock[grant_idx]) state_d = LOCKED;
      end
      LOCKED: begin
        if (gray_ready) begin
          if (grant_any) state_d = req_lock[grant_idx] ? LOCKED : IDLE;
          else if (!req_lock[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gray_req_d  = grant_any;
    gray_addr_d = grant_any ? addr_arr[grant_idx] : gray_addr_q;
    tag_vld_d   = {tag_vld_q[NST-2:0], grant_any};
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < NST; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // The last tag stage lines up with gray_data for the read it describes.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[NST-1]) begin
      rsp_valid_d[tag_idx_q[NST-1]] = 1'b1;
      rsp_data_d                    = gray_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      owner_q     <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < NST; s++) tag_idx_q[s] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (gray_ready) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        owner_q <= owner_d;
      end
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      tag_vld_q   <= tag_vld_d;
      for (int s = 0; s < NST; s++) tag_idx_q[s] <= tag_idx_d[s];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Bench for gray_port_arbiter: two instances (MEM_LAT 1 and 3) share all
// requester inputs; a high-level model predicts grants and response order.
module tb_gray_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    req_lock;
  logic          gray_ready;

  logic [1:0]    g1, rv1, g3, rv3;
  logic [DW-1:0] rd1, rd3, gd1, gd3;
  logic          gr1, gr3;
  logic [AW-1:0] ga1, ga3;

  gray_port_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_grant(g1), .rsp_valid(rv1), .rsp_data(rd1),
    .gray_req(gr1), .gray_addr(ga1), .gray_ready(gray_ready), .gray_data(gd1)
  );

  gray_port_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_grant(g3), .rsp_valid(rv3), .rsp_data(rd3),
    .gray_req(gr3), .gray_addr(ga3), .gray_ready(gray_ready), .gray_data(gd3)
  );

  // ---------------- clock / memory models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] m1;
  logic [DW-1:0] m3 [3];
  initial begin
    m1 = '0;
    for (int i = 0; i < 3; i++) m3[i] = '0;
  end
  always @(posedge clk) begin
    m1    <= ga1[7:0];
    m3[0] <= ga3[7:0];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign gd1 = m1;
  assign gd3 = m3[2];

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int mptr, mowner;
  bit mlocked;
  logic          e_greq;
  logic [AW-1:0] e_gaddr;
  logic [DW-1:0] e_rd1, e_rd3;
  // {due cycle[31:16], requester[15:8], pixel[7:0]}
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [1:0] v, input int i);
    logic [31:0] iv;
    iv = i;
    return v[iv[0]];
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return (i == 0) ? req_addr[AW-1:0] : req_addr[2*AW-1:AW];
  endfunction

  // Returns the requester the rules say wins this cycle, or -1.
  function automatic int model_grant();
    if (!gray_ready) return -1;
    if (mlocked && bit_of(req_lock, mowner)) return bit_of(req_valid, mowner) ? mowner : -1;
    for (int k = 1; k <= 2; k++) begin
      int c = (mptr + k) % 2;
      if (bit_of(req_valid, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 1; mowner = 0; mlocked = 0;
    e_greq = 0; e_gaddr = '0; e_rd1 = '0; e_rd3 = '0;
    exp_q1.delete();
    exp_q3.delete();
  endtask

  // Called after the edge (cyc already advanced) with the grant of the previous cycle.
  task automatic model_update(input int g);
    logic [AW-1:0] a;
    if (!gray_ready) begin
      e_greq = 0;
    end else if (g >= 0) begin
      a = addr_of(g);
      mptr = g; mowner = g; mlocked = bit_of(req_lock, g);
      e_greq = 1; e_gaddr = a;
      exp_q1.push_back({16'(cyc + 2), 8'(g), a[7:0]});
      exp_q3.push_back({16'(cyc + 4), 8'(g), a[7:0]});
    end else begin
      e_greq = 0;
      if (!bit_of(req_lock, mowner)) mlocked = 0;
    end
  endtask

  task automatic chk_rsp(input int which);
    logic [31:0] h;
    logic        hit;
    hit = 0;
    h   = '0;
    if (which == 1 && exp_q1.size() > 0 && exp_q1[0][31:16] == 16'(cyc)) begin
      h = exp_q1.pop_front(); hit = 1;
    end
    if (which == 3 && exp_q3.size() > 0 && exp_q3[0][31:16] == 16'(cyc)) begin
      h = exp_q3.pop_front(); hit = 1;
    end
    if (which == 1) begin
      if (hit) e_rd1 = h[7:0];
      chk("rsp_valid1", 32'(rv1), hit ? (32'd1 << h[15:8]) : 32'd0);
      chk("rsp_data1", 32'(rd1), 32'(e_rd1));
    end else begin
      if (hit) e_rd3 = h[7:0];
      chk("rsp_valid3", 32'(rv3), hit ? (32'd1 << h[15:8]) : 32'd0);
      chk("rsp_data3", 32'(rd3), 32'(e_rd3));
    end
  endtask

  // One clock cycle with the currently driven inputs; returns the model grant.
  task automatic step(output int g);
    logic [1:0] eg;
    #1;
    g  = model_grant();
    eg = (g >= 0) ? (2'b01 << g) : 2'b00;
    chk("grant1", 32'(g1), 32'(eg));
    chk("grant3", 32'(g3), 32'(eg));
    @(posedge clk);
    cyc++;
    model_update(g);
    #1;
    chk("gray_req1", 32'(gr1), 32'(e_greq));
    chk("gray_req3", 32'(gr3), 32'(e_greq));
    chk("gray_addr1", 32'(ga1), 32'(e_gaddr));
    chk("gray_addr3", 32'(ga3), 32'(e_gaddr));
    chk_rsp(1);
    chk_rsp(3);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic r,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    req_valid  = v;
    req_lock   = l;
    gray_ready = r;
    req_addr   = {a1, a0};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant1"}, 32'(g1), 0);
    chk({tag, "_grant3"}, 32'(g3), 0);
    chk({tag, "_rsp_valid1"}, 32'(rv1), 0);
    chk({tag, "_rsp_valid3"}, 32'(rv3), 0);
    chk({tag, "_rsp_data1"}, 32'(rd1), 0);
    chk({tag, "_rsp_data3"}, 32'(rd3), 0);
    chk({tag, "_gray_req1"}, 32'(gr1), 0);
    chk({tag, "_gray_req3"}, 32'(gr3), 0);
    chk({tag, "_gray_addr1"}, 32'(ga1), 0);
    chk({tag, "_gray_addr3"}, 32'(ga3), 0);
  endtask

  task automatic apply_reset();
    drive(2'b00, 2'b00, 1'b1, '0, '0);
    reset = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    v;
    logic [1:0]    l;
    logic          r;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    g;
  } vec_t;

  vec_t tbl[$];

  task automatic mk(input logic [1:0] v, input logic [1:0] l, input logic r, input logic [1:0] g);
    vec_t e;
    e.v = v; e.l = l; e.r = r; e.g = g;
    e.a0 = AW'(tbl.size() * 7 + 2);
    e.a1 = AW'(tbl.size() * 13 + 9);
    tbl.push_back(e);
  endtask

  task automatic mkb(input logic [AW-1:0] a0);
    vec_t e;
    e.v = 2'b11; e.l = 2'b01; e.r = 1'b1; e.g = 2'b01;
    e.a0 = a0; e.a1 = 14'd300;
    tbl.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [AW-1:0] burst [9];
    logic [1:0]    pv;
    logic [AW-1:0] pa [2];
    logic [1:0]    pl;

    burst[0] = 14'd0;   burst[1] = 14'd1;   burst[2] = 14'd2;
    burst[3] = 14'd128; burst[4] = 14'd129; burst[5] = 14'd130;
    burst[6] = 14'd256; burst[7] = 14'd257; burst[8] = 14'd258;

    // Fairness from reset: alternate starting with requester 0.
    for (int i = 0; i < 8; i++) mk(2'b11, 2'b00, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    // Locked burst of 9, then requester 1 wins as lock drops.
    for (int i = 0; i < 9; i++) mkb(burst[i]);
    mk(2'b11, 2'b00, 1'b1, 2'b10);
    // Lock bubble.
    mk(2'b11, 2'b01, 1'b1, 2'b01);
    mk(2'b10, 2'b01, 1'b1, 2'b00);
    mk(2'b10, 2'b01, 1'b1, 2'b00);
    mk(2'b11, 2'b00, 1'b1, 2'b10);
    // Backpressure, then requester after ptr.
    for (int i = 0; i < 3; i++) mk(2'b11, 2'b00, 1'b0, 2'b00);
    mk(2'b11, 2'b00, 1'b1, 2'b01);
    // gray_ready falling while locked keeps the lock.
    mk(2'b11, 2'b01, 1'b1, 2'b10);
    mk(2'b11, 2'b01, 1'b1, 2'b01);
    mk(2'b11, 2'b01, 1'b0, 2'b00);
    mk(2'b11, 2'b01, 1'b0, 2'b00);
    mk(2'b11, 2'b01, 1'b1, 2'b01);
    mk(2'b11, 2'b00, 1'b1, 2'b10);
    // req_lock without a grant does nothing.
    mk(2'b11, 2'b10, 1'b1, 2'b01);
    mk(2'b11, 2'b10, 1'b1, 2'b10);
    mk(2'b11, 2'b10, 1'b1, 2'b10);
    mk(2'b11, 2'b00, 1'b1, 2'b01);
    // Idle keeps ptr; single requester 1.
    mk(2'b00, 2'b00, 1'b1, 2'b00);
    mk(2'b00, 2'b00, 1'b1, 2'b00);
    mk(2'b11, 2'b00, 1'b1, 2'b10);
    mk(2'b10, 2'b00, 1'b1, 2'b10);
    for (int i = 0; i < 5; i++) mk(2'b00, 2'b00, 1'b1, 2'b00);

    reset = 1'b0;
    drive(2'b00, 2'b00, 1'b1, '0, '0);
    #2;
    apply_reset();

    // Single requester, addr 129 -> pixel 0x81.
    drive(2'b01, 2'b00, 1'b1, 14'd129, 14'd0);
    #1;
    chk("single_grant", 32'(g1), 32'h1);
    step(g);
    chk("single_gray_req", 32'(gr1), 32'h1);
    chk("single_gray_addr", 32'(ga1), 32'd129);
    drive(2'b00, 2'b00, 1'b1, 14'd0, 14'd0);
    step(g);
    step(g);
    chk("single_rsp_valid1", 32'(rv1), 32'h1);
    chk("single_rsp_data1", 32'(rd1), 32'h81);
    step(g);
    step(g);
    chk("single_rsp_valid3", 32'(rv3), 32'h1);
    chk("single_rsp_data3", 32'(rd3), 32'h81);
    step(g);

    // Directed table from a fresh reset.
    apply_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].a0, tbl[i].a1);
      #1;
      chk($sformatf("tbl_grant[%0d]", i), 32'(g1), 32'(tbl[i].g));
      step(g);
    end

    // Randomised traffic; requesters hold address until granted.
    pv = 2'b00; pl = 2'b00;
    pa[0] = '0; pa[1] = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          pv[i] = 1'b1;
          pa[i] = AW'($urandom_range(0, (1 << AW) - 1));
        end
        if ($urandom_range(0, 99) < 20) pl[i] = ~pl[i];
      end
      drive(pv, pl, ($urandom_range(0, 9) != 0), pa[0], pa[1]);
      step(g);
      if (g >= 0) pv[g] = 1'b0;
    end

    // Reset one cycle after a grant with reads in flight (MEM_LAT=3 instance).
    drive(2'b01, 2'b00, 1'b1, 14'd55, 14'd0);
    #1;
    chk("midflight_grant", 32'(g1), 32'h1);
    step(g);
    drive(2'b00, 2'b00, 1'b1, 14'd0, 14'd0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midflight");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(g);
    drive(2'b11, 2'b00, 1'b1, 14'd60, 14'd61);
    #1;
    chk("post_reset_grant1", 32'(g1), 32'h1);
    chk("post_reset_grant3", 32'(g3), 32'h1);
    step(g);
    drive(2'b00, 2'b00, 1'b1, 14'd0, 14'd0);
    for (int i = 0; i < 6; i++) step(g);

    chk("queue1_drained", 32'(exp_q1.size()), 0);
    chk("queue3_drained", 32'(exp_q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
